// File: rtl/systolic_feeder_if.sv
// Operand-feeder bus: matrix write port, run control and the skewed operand lanes
// that drive the west and north edges of the systolic MAC array.
interface systolic_feeder_if #(
  parameter int N  = 2,
  parameter int DW = 8
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic              wr_en;
  logic              wr_sel;
  logic [AW-1:0]     wr_row;
  logic [AW-1:0]     wr_col;
  logic [DW-1:0]     wr_data;
  logic              wr_err;
  logic              start;
  logic              busy;
  logic              done;
  logic              pe_clr;
  logic              feed_valid;
  logic [N*DW-1:0]   a_west;
  logic [N*DW-1:0]   b_north;

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output wr_err, busy, done, pe_clr, feed_valid, a_west, b_north
  );

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  wr_err, busy, done, pe_clr, feed_valid, a_west, b_north
  );
endinterface

// File: rtl/systolic_feeder.sv
// Operand transmitter for an NxN output-stationary systolic MAC array: stores A and B,
// then streams skewed A rows (west) and B columns (north) after an accumulator clear.

// One operand lane: registers element (k - LANE) of its row/column vector, or 0 outside it.
module systolic_feeder_lane #(
  parameter int N    = 2,
  parameter int DW   = 8,
  parameter int KW   = 2,
  parameter int LANE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  feed_i,
  input  logic [KW-1:0]         k_i,
  input  logic [N-1:0][DW-1:0]  vec_i,
  output logic [DW-1:0]         lane_o
);
  logic [DW-1:0] lane_d, lane_q;

  always_comb begin
    lane_d = '0;
    if (feed_i) begin
      for (int m = 0; m < N; m++) begin
        if (int'(k_i) == m + LANE) lane_d = vec_i[m];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lane_q <= '0;
    else        lane_q <= lane_d;
  end

  assign lane_o = lane_q;
endmodule

module systolic_feeder #(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  systolic_feeder_if.slave   bus
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = $clog2(3*N-2);
  localparam logic [KW-1:0] KLAST = KW'(3*N-3);
  localparam logic [AW:0]   NLIM  = (AW+1)'(N);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FEED, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          feed_d, clr_d, done_d, busy_d;
  logic          busy_q, done_q, clr_q, fv_q, wr_err_q;

  // B is kept transposed so each north lane sees its column as a contiguous vector.
  logic [N-1:0][N-1:0][DW-1:0] a_mem_q, bt_mem_q;
  logic [N-1:0][DW-1:0]        a_lane, b_lane;

  logic in_range, wr_ok;

  assign in_range = ({1'b0, bus.wr_row} < NLIM) && ({1'b0, bus.wr_col} < NLIM);
  assign wr_ok    = bus.wr_en && !busy_q && in_range;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    feed_d  = 1'b0;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
          clr_d   = 1'b1;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        k_d     = '0;
        feed_d  = 1'b1;
      end
      S_FEED: begin
        if (k_q == KLAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          k_d    = k_q + 1'b1;
          feed_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clr_q    <= 1'b0;
      fv_q     <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      clr_q    <= clr_d;
      fv_q     <= feed_d;
      wr_err_q <= bus.wr_en && (busy_q || !in_range);
    end
  end

  // A write landing on the start edge is visible to vector 0, registered one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_mem_q  <= '0;
      bt_mem_q <= '0;
    end else if (wr_ok) begin
      if (!bus.wr_sel) a_mem_q[bus.wr_row][bus.wr_col]  <= bus.wr_data;
      else             bt_mem_q[bus.wr_col][bus.wr_row] <= bus.wr_data;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_feeder_lane #(.N(N), .DW(DW), .KW(KW), .LANE(i)) u_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .feed_i (feed_d),
      .k_i    (k_d),
      .vec_i  (a_mem_q[i]),
      .lane_o (a_lane[i])
    );
    systolic_feeder_lane #(.N(N), .DW(DW), .KW(KW), .LANE(i)) u_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .feed_i (feed_d),
      .k_i    (k_d),
      .vec_i  (bt_mem_q[i]),
      .lane_o (b_lane[i])
    );
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pe_clr     = clr_q;
  assign bus.feed_valid = fv_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.a_west     = a_lane;
  assign bus.b_north    = b_lane;
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: a matrix-level model predicts events and C results;
// a negedge monitor pops and compares, and a behavioural PE array consumes the lanes.
module tb_systolic_feeder;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 1;

  typedef struct packed {
    logic [31:0]     stamp;
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   ecnt = 0;
  int   nvec = 0;
  int   nfail = 0;
  int   bstart = -1000;

  int ma[N][N];
  int mb[N][N];
  int pa[N][N], pb[N][N], pc[N][N];
  int na[N][N], nb[N][N];

  vec_t vec_q[$];
  int   clr_q[$];
  int   done_q[$];
  int   err_q[$];
  logic [N*N-1:0][31:0] cexp_q[$];

  systolic_feeder_if #(.N(N), .DW(DW)) bus ();

  systolic_feeder #(.N(N), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt = ecnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, ecnt, act, exp);
    end
  endtask

  task automatic miss(input string name);
    nvec++;
    nfail++;
    $display("FAIL %s @edge %0d: output with no expected entry", name, ecnt);
  endtask

  function automatic bit busy_at(input int e);
    return (e >= bstart) && (e <= bstart + 3*N - 1);
  endfunction

  // Model: next edge e accepts writes/start exactly when the feeder was idle in the cycle before.
  task automatic cyc(input logic we, input logic sel, input int r, input int c,
                     input int d, input logic st);
    int e;
    bit b;
    vec_t v;
    logic [N*N-1:0][31:0] ce;
    bus.wr_en   = we;
    bus.wr_sel  = sel;
    bus.wr_row  = r[AW-1:0];
    bus.wr_col  = c[AW-1:0];
    bus.wr_data = d[DW-1:0];
    bus.start   = st;
    e = ecnt + 1;
    b = busy_at(e - 1);
    if (we) begin
      if (b) err_q.push_back(e);
      else if (!sel) ma[r][c] = d & 8'hff;
      else           mb[r][c] = d & 8'hff;
    end
    if (st && !b) begin
      bstart = e;
      clr_q.push_back(e);
      for (int k = 0; k <= 3*N-3; k++) begin
        v.stamp = 32'(e + 1 + k);
        v.a = '0;
        v.b = '0;
        for (int l = 0; l < N; l++) begin
          if (k - l >= 0 && k - l < N) begin
            v.a[l*DW +: DW] = ma[l][k-l][DW-1:0];
            v.b[l*DW +: DW] = mb[k-l][l][DW-1:0];
          end
        end
        vec_q.push_back(v);
      end
      done_q.push_back(e + 3*N - 1);
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ce[i*N+j] = 0;
          for (int k = 0; k < N; k++) ce[i*N+j] += 32'(ma[i][k] * mb[k][j]);
        end
      cexp_q.push_back(ce);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int t = 0; t < n; t++) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic wr(input logic sel, input int r, input int c, input int d);
    cyc(1'b1, sel, r, c, d, 1'b0);
  endtask

  task automatic load_ab(input int a00, a01, a10, a11, b00, b01, b10, b11);
    wr(0, 0, 0, a00); wr(0, 0, 1, a01); wr(0, 1, 0, a10); wr(0, 1, 1, a11);
    wr(1, 0, 0, b00); wr(1, 0, 1, b01); wr(1, 1, 0, b10); wr(1, 1, 1, b11);
  endtask

  task automatic check_zero_outputs(input string name);
    chk(name, {57'd0, bus.busy, bus.done, bus.pe_clr, bus.feed_valid, bus.wr_err, 2'b00}, 64'd0);
    chk({name, "_lanes"}, {32'd0, bus.a_west, bus.b_north}, 64'd0);
  endtask

  task automatic model_reset();
    vec_q.delete(); clr_q.delete(); done_q.delete(); err_q.delete(); cexp_q.delete();
    bstart = -1000;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
  endtask

  // Monitor plus behavioural output-stationary PE array fed by the DUT lanes.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          pa[i][j] = 0; pb[i][j] = 0; pc[i][j] = 0;
        end
    end else begin
      chk("busy", {63'd0, bus.busy}, {63'd0, busy_at(ecnt)});
      if (bus.pe_clr) begin
        if (clr_q.size() == 0) miss("pe_clr");
        else chk("pe_clr_edge", 64'(clr_q.pop_front()), 64'(ecnt));
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            pa[i][j] = 0; pb[i][j] = 0; pc[i][j] = 0;
          end
      end
      if (bus.wr_err) begin
        if (err_q.size() == 0) miss("wr_err");
        else chk("wr_err_edge", 64'(err_q.pop_front()), 64'(ecnt));
      end
      if (bus.feed_valid) begin
        if (vec_q.size() == 0) miss("feed_valid");
        else begin
          vec_t v;
          v = vec_q.pop_front();
          chk("vec_edge", 64'(v.stamp), 64'(ecnt));
          chk("a_west", 64'(bus.a_west), 64'(v.a));
          chk("b_north", 64'(bus.b_north), 64'(v.b));
        end
      end else begin
        chk("lanes_idle", {32'd0, bus.a_west, bus.b_north}, 64'd0);
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          na[i][j] = (j == 0) ? int'(bus.a_west[i*DW +: DW]) : pa[i][j-1];
          nb[i][j] = (i == 0) ? int'(bus.b_north[j*DW +: DW]) : pb[i-1][j];
          pc[i][j] += na[i][j] * nb[i][j];
        end
      pa = na;
      pb = nb;
      if (bus.done) begin
        if (done_q.size() == 0) miss("done");
        else begin
          logic [N*N-1:0][31:0] ce;
          chk("done_edge", 64'(done_q.pop_front()), 64'(ecnt));
          ce = cexp_q.pop_front();
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
              chk($sformatf("C%0d%0d", i, j), 64'(pc[i][j]), 64'(ce[i*N+j]));
        end
      end
    end
  end

  initial begin
    bus.wr_en = 0; bus.wr_sel = 0; bus.wr_row = '0; bus.wr_col = '0;
    bus.wr_data = '0; bus.start = 0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic product, then back-to-back with B = I.
    load_ab(1, 2, 3, 4, 5, 6, 7, 8);
    cyc(0, 0, 0, 0, 0, 1);
    idle(7);
    load_ab(1, 2, 3, 4, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    idle(7);

    // Write attempted during FEED is dropped; the following run still sees A00=1.
    load_ab(1, 2, 3, 4, 5, 6, 7, 8);
    cyc(0, 0, 0, 0, 0, 1);
    idle(1);
    wr(0, 0, 0, 9);
    idle(6);
    cyc(0, 0, 0, 0, 0, 1);
    idle(7);

    // Repeated start while busy is ignored.
    cyc(0, 0, 0, 0, 0, 1);
    for (int t = 0; t < 4; t++) cyc(0, 0, 0, 0, 0, 1);
    idle(4);

    // Async reset at FEED k=1 clears outputs and storage.
    cyc(0, 0, 0, 0, 0, 1);
    idle(2);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("midrun_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 1);
    idle(7);
    load_ab(1, 2, 3, 4, 5, 6, 7, 8);
    cyc(0, 0, 0, 0, 0, 1);
    idle(7);

    // Write and start in the same idle cycle.
    cyc(1, 0, 1, 1, 10, 1);
    idle(7);

    // Randomised writes and starts.
    for (int t = 0; t < 300; t++)
      cyc(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
          int'($urandom_range(0, N-1)), int'($urandom_range(0, N-1)),
          int'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0));
    idle(12);

    chk("vec_q_left",  64'(vec_q.size()),  64'd0);
    chk("clr_q_left",  64'(clr_q.size()),  64'd0);
    chk("done_q_left", 64'(done_q.size()), 64'd0);
    chk("err_q_left",  64'(err_q.size()),  64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
